// File: rtl/multi_channel_tick_generator_if.sv
// Configuration write bus for multi_channel_tick_generator.
// The master drives register writes; the tick generator is the slave.
interface multi_channel_tick_generator_if #(
  parameter int WIDTH    = 26,
  parameter int CHANNELS = 4,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic             cfg_we;
  logic [CW-1:0]    cfg_chan;
  logic [1:0]       cfg_sel;
  logic [WIDTH-1:0] cfg_data;

  modport master (output cfg_we, cfg_chan, cfg_sel, cfg_data);
  modport slave  (input  cfg_we, cfg_chan, cfg_sel, cfg_data);
endinterface

// File: rtl/multi_channel_tick_generator.sv
// Random tick source: seed counter -> Fibonacci LFSR -> CHANNELS range comparators.
// Define RANDOM_TICK_COOLDOWN_EN to add per-channel cooldown (cool/cnt) registers.

module multi_channel_tick_generator_chan #(
  parameter int WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             eval,
  input  logic             en,
  input  logic             we_lo,
  input  logic             we_hi,
`ifdef RANDOM_TICK_COOLDOWN_EN
  input  logic             we_cool,
`endif
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] state,
  output logic             tick
);
  logic [WIDTH-1:0] lower_q, lower_d, upper_q, upper_d;
  logic             tick_q, tick_d, hit;
`ifdef RANDOM_TICK_COOLDOWN_EN
  logic [7:0]       cool_q, cool_d, cnt_q, cnt_d;
`endif

  always_comb begin
    lower_d = lower_q;
    upper_d = upper_q;
    if (we_lo) lower_d = data;
    if (we_hi) upper_d = data;
    // Comparison uses the pre-write bounds, so a write on an eval edge does not affect it.
    hit    = en & (lower_q <= state) & (state <= upper_q);
`ifdef RANDOM_TICK_COOLDOWN_EN
    hit    = hit & (cnt_q == 8'd0);
    cool_d = cool_q;
    if (we_cool) cool_d = data[7:0];
    cnt_d  = cnt_q;
    if (eval) begin
      if (hit)                 cnt_d = cool_q;
      else if (cnt_q != 8'd0)  cnt_d = cnt_q - 8'd1;
    end
`endif
    tick_d = eval & hit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lower_q <= '0;
      upper_q <= '0;
      tick_q  <= 1'b0;
`ifdef RANDOM_TICK_COOLDOWN_EN
      cool_q  <= 8'd0;
      cnt_q   <= 8'd0;
`endif
    end else begin
      lower_q <= lower_d;
      upper_q <= upper_d;
      tick_q  <= tick_d;
`ifdef RANDOM_TICK_COOLDOWN_EN
      cool_q  <= cool_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign tick = tick_q;
endmodule

module multi_channel_tick_generator #(
  parameter int               WIDTH    = 26,
  parameter logic [WIDTH-1:0] TAP_MASK = 26'h2000023,
  parameter int               CHANNELS = 4,
  parameter int               CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          reseed,
  input  logic                          game_tick,
  input  logic [CHANNELS-1:0]           enable,
  multi_channel_tick_generator_if.slave cfg,
  output logic [CHANNELS-1:0]           random_tick,
  output logic [WIDTH-1:0]              random_value
);
  logic [WIDTH-1:0] seed_q, seed_d, state_q, state_d;
  logic             eval_q, eval_d;

  always_comb begin
    seed_d  = seed_q + WIDTH'(1);
    state_d = state_q;
    // Reseed wins over a step; a zero seed would lock the LFSR, so it becomes 1.
    if (reseed)
      state_d = (seed_q == '0) ? WIDTH'(1) : seed_q;
    else if (game_tick)
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAP_MASK)};
    eval_d  = game_tick & ~reseed;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seed_q  <= '0;
      state_q <= WIDTH'(1);
      eval_q  <= 1'b0;
    end else begin
      seed_q  <= seed_d;
      state_q <= state_d;
      eval_q  <= eval_d;
    end
  end

  assign random_value = state_q;

  // Channel indices past CHANNELS-1 and cfg_sel==3 match no write enable.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic sel;
    assign sel = cfg.cfg_we & (cfg.cfg_chan == CW'(i));

    multi_channel_tick_generator_chan #(.WIDTH(WIDTH)) u_chan (
      .clock   (clock),
      .reset   (reset),
      .eval    (eval_q),
      .en      (enable[i]),
      .we_lo   (sel & (cfg.cfg_sel == 2'd0)),
      .we_hi   (sel & (cfg.cfg_sel == 2'd1)),
`ifdef RANDOM_TICK_COOLDOWN_EN
      .we_cool (sel & (cfg.cfg_sel == 2'd2)),
`endif
      .data    (cfg.cfg_data),
      .state   (state_q),
      .tick    (random_tick[i])
    );
  end
endmodule

// File: tb/tb_multi_channel_tick_generator.sv
// Directed self-checking bench for multi_channel_tick_generator (default parameters).
module tb_multi_channel_tick_generator;
  localparam int WIDTH = 26;
  localparam int CH    = 4;

  logic             clock, reset, reseed, game_tick;
  logic [CH-1:0]    enable, random_tick;
  logic [WIDTH-1:0] random_value;
  logic [WIDTH-1:0] seed_m;
  int               n_chk, n_err;

  multi_channel_tick_generator_if #(.WIDTH(WIDTH), .CHANNELS(CH)) cfg_if ();

  multi_channel_tick_generator dut (
    .clock        (clock),
    .reset        (reset),
    .reseed       (reseed),
    .game_tick    (game_tick),
    .enable       (enable),
    .cfg          (cfg_if),
    .random_tick  (random_tick),
    .random_value (random_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running seed counter model for reseed expectations.
  always @(posedge clock or posedge reset)
    if (reset) seed_m <= '0;
    else       seed_m <= seed_m + WIDTH'(1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; reseed = 1'b0; game_tick = 1'b0; enable = '0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_chan = '0; cfg_if.cfg_sel = '0; cfg_if.cfg_data = '0;
    edge_(); edge_();
    reset = 1'b0;
  endtask

  task automatic cfg_wr(input int chan, input int sel, input logic [WIDTH-1:0] data);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_chan = 2'(chan); cfg_if.cfg_sel = 2'(sel); cfg_if.cfg_data = data;
    edge_();
    cfg_if.cfg_we = 1'b0;
  endtask

  // One-cycle game_tick: step edge, evaluation edge, then the pulse must be gone.
  task automatic gtick(input string tag, input logic [WIDTH-1:0] exp_val, input logic [CH-1:0] exp_tick);
    game_tick = 1'b1;
    edge_();
    game_tick = 1'b0;
    chk({tag, "_val"}, 32'(random_value), 32'(exp_val));
    chk({tag, "_tick0"}, 32'(random_tick), 32'd0);
    edge_();
    chk({tag, "_tick"}, 32'(random_tick), 32'(exp_tick));
    edge_();
    chk({tag, "_tick_end"}, 32'(random_tick), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] exp_seed;
    logic             c6;
    n_chk = 0; n_err = 0;
    c6 = 1'b1;
`ifdef RANDOM_TICK_COOLDOWN_EN
    c6 = 1'b0;
`endif

    // Reset values, checked while reset is held.
    reset = 1'b1; reseed = 1'b0; game_tick = 1'b0; enable = '0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_chan = '0; cfg_if.cfg_sel = '0; cfg_if.cfg_data = '0;
    #2;
    chk("rst_val", 32'(random_value), 32'd1);
    chk("rst_tick", 32'(random_tick), 32'd0);

    // LFSR sequence 1 -> 3 -> 6 -> 13, nothing programmed so no ticks.
    do_reset();
    enable = '1;
    gtick("lfsr1", 26'd3, 4'b0000);
    gtick("lfsr2", 26'd6, 4'b0000);
    gtick("lfsr3", 26'h000000D, 4'b0000);

    // Range hits: ch0 [3,6], ch1 [13,13], ch2 full range but disabled, ch3 lower>upper.
    do_reset();
    cfg_wr(0, 0, 26'd3);  cfg_wr(0, 1, 26'd6);
    cfg_wr(1, 0, 26'd13); cfg_wr(1, 1, 26'd13);
    cfg_wr(2, 0, 26'd1);  cfg_wr(2, 1, '1);
    cfg_wr(3, 0, 26'd6);  cfg_wr(3, 1, 26'd3);
    cfg_wr(0, 3, 26'd0);
    enable = 4'b1011;
    gtick("hit3", 26'd3, 4'b0001);
    gtick("hit6", 26'd6, 4'b0001);
    gtick("hit13", 26'd13, 4'b0010);

    // Cooldown of one evaluation on ch0.
    do_reset();
    cfg_wr(0, 0, 26'd3); cfg_wr(0, 1, 26'd6); cfg_wr(0, 2, 26'd1);
    enable = 4'b0001;
    gtick("cool3", 26'd3, 4'b0001);
    gtick("cool6", 26'd6, {3'b000, c6});
    gtick("cool13", 26'd13, 4'b0000);

    // game_tick held for three cycles: pipelined evaluations.
    do_reset();
    cfg_wr(0, 0, 26'd3); cfg_wr(0, 1, 26'd6);
    enable = 4'b0001;
    game_tick = 1'b1;
    edge_(); chk("hold_v1", 32'(random_value), 32'd3);  chk("hold_t1", 32'(random_tick), 32'd0);
    edge_(); chk("hold_v2", 32'(random_value), 32'd6);  chk("hold_t2", 32'(random_tick), 32'd1);
    edge_(); chk("hold_v3", 32'(random_value), 32'd13); chk("hold_t3", 32'(random_tick), 32'd1);
    game_tick = 1'b0;
    edge_(); chk("hold_t4", 32'(random_tick), 32'd0);

    // Reseed on first edge after reset (counter 0) loads 1.
    do_reset();
    reseed = 1'b1; edge_(); reseed = 1'b0;
    chk("reseed0", 32'(random_value), 32'd1);

    // Reseed when counter reads 5.
    do_reset();
    repeat (5) edge_();
    reseed = 1'b1; edge_(); reseed = 1'b0;
    chk("reseed5", 32'(random_value), 32'd5);

    // reseed + game_tick: only reseed, no evaluation even with a full-range channel.
    do_reset();
    cfg_wr(0, 0, 26'd1); cfg_wr(0, 1, '1);
    enable = 4'b0001;
    exp_seed = (seed_m == '0) ? WIDTH'(1) : seed_m;
    reseed = 1'b1; game_tick = 1'b1;
    edge_();
    reseed = 1'b0; game_tick = 1'b0;
    chk("both_val", 32'(random_value), 32'(exp_seed));
    edge_(); chk("both_tick", 32'(random_tick), 32'd0);

    // Config write coincident with evaluation: old lower bound decides.
    do_reset();
    cfg_wr(0, 0, 26'd3); cfg_wr(0, 1, 26'd6);
    enable = 4'b0001;
    game_tick = 1'b1; edge_(); game_tick = 1'b0;
    chk("cfgev_val", 32'(random_value), 32'd3);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_chan = 2'd0; cfg_if.cfg_sel = 2'd0; cfg_if.cfg_data = 26'd7;
    edge_();
    cfg_if.cfg_we = 1'b0;
    chk("cfgev_old", 32'(random_tick), 32'd1);
    edge_(); chk("cfgev_end", 32'(random_tick), 32'd0);
    gtick("cfgev_new", 26'd6, 4'b0000);

    // Reset mid-operation with a pulse high, countdown running and evaluation pending.
    do_reset();
    cfg_wr(0, 0, 26'd3); cfg_wr(0, 1, 26'd6); cfg_wr(0, 2, 26'd1);
    enable = 4'b0001;
    game_tick = 1'b1;
    edge_();
    edge_();
    game_tick = 1'b0;
    chk("midrst_pre", 32'(random_tick), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_val", 32'(random_value), 32'd1);
    chk("midrst_tick", 32'(random_tick), 32'd0);
    #1 reset = 1'b0;
    edge_(); chk("midrst_post1", 32'(random_tick), 32'd0);
    edge_(); chk("midrst_post2", 32'(random_tick), 32'd0);
    chk("midrst_hold", 32'(random_value), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
